tm1637_frame_driver: RTL

- Native TM1637 two-wire display controller, parametrised by digit count, bit rate and refresh mode; replaces ROM-stepped sequencing through a generic SPI master in DIO mode.
- Generates START/STOP conditions, LSB-first bytes and 9th-clock ACK sampling itself, with an open-drain DIO.
- On each update it sends a complete three-frame refresh from a latched digit buffer: data command, address plus digits, display control.
- Sits between the user logic's segment buffer and the board pins tm1637_clk / tm1637_dio.

---
 rtl/tm1637_frame_driver.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/tm1637_frame_driver.sv
// TM1637 two-wire display driver: START/STOP generation, LSB-first bytes,
// 9th-clock ACK sampling and an open-drain DIO. Each refresh sends the data
// command, the address plus all digits, and the display control byte from
// a shadow copy of the inputs taken at start.
module tm1637_frame_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 250,
  parameter int REFRESH_PERIOD = 0
) (
  input  logic                    clk_50M,
  input  logic                    rst_n,
  input  logic [8*NUM_DIGITS-1:0] seg_data,
  input  logic [2:0]              brightness,
  input  logic                    display_on,
  input  logic                    update,
  output logic                    busy,
  output logic                    done,
  output logic                    ack_err,
  output logic                    tm1637_clk,
  output logic                    tm1637_dio_oe,
  input  logic                    tm1637_dio_in,
  output logic [3:0]              dbg_state
);

  localparam int PH_W = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1;
  localparam int BY_W = ($clog2(NUM_DIGITS + 1) > 0) ? $clog2(NUM_DIGITS + 1) : 1;
  localparam int RF_W = ($clog2(REFRESH_PERIOD + 1) > 0) ? $clog2(REFRESH_PERIOD + 1) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [BY_W-1:0] BY_LAST = BY_W'(NUM_DIGITS);
  localparam logic [RF_W-1:0] RF_LAST = RF_W'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE, S_START0, S_START1, S_BIT_LO, S_BIT_HI,
    S_ACK_LO, S_ACK_HI, S_STOP0, S_STOP1, S_STOP2
  } state_e;

  typedef enum logic [1:0] {FR_CMD, FR_ADDR, FR_CTRL} frame_e;

  state_e                        state_q, state_d;
  frame_e                        frame_q, frame_d;
  logic [BY_W-1:0]               byte_q, byte_d;
  logic [2:0]                    bit_q, bit_d;
  logic [PH_W-1:0]               ph_q, ph_d;
  logic [RF_W-1:0]               ref_q, ref_d;
  logic [NUM_DIGITS-1:0][7:0]    seg_q, seg_d;
  logic [2:0]                    bright_q, bright_d;
  logic                          on_q, on_d;
  logic                          ack_err_q, ack_err_d;
  logic                          done_q, done_d;
  logic                          clk_q, clk_d;
  logic                          oe_q, oe_d;
  logic [1:0]                    dio_sync_q;
  logic                          phase_end, auto_hit, start;
  logic [7:0]                    nxt_byte;
  logic                          nxt_bit;

  // Byte on the wire for a given frame and byte position.
  function automatic logic [7:0] tx_byte(input frame_e fr, input logic [BY_W-1:0] idx,
                                         input logic [NUM_DIGITS-1:0][7:0] seg,
                                         input logic on, input logic [2:0] br);
    logic [7:0] b;
    b = 8'h40;
    case (fr)
      FR_CMD:  b = 8'h40;
      FR_ADDR: begin
        b = 8'hC0;
        for (int k = 0; k < NUM_DIGITS; k++)
          if (int'(idx) == k + 1) b = seg[k];
      end
      default: b = {4'h8, on, br};
    endcase
    return b;
  endfunction

  assign phase_end = (ph_q == PH_LAST);
  assign auto_hit  = (REFRESH_PERIOD > 0) && (ref_q == RF_LAST);
  assign start     = (state_q == S_IDLE) && (update || auto_hit);

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign ack_err       = ack_err_q;
  assign tm1637_clk    = clk_q;
  assign tm1637_dio_oe = oe_q;
  assign dbg_state     = state_q;

  // Sequencer: phase timer, bit/byte/frame stepping, start latching, ACK check.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    byte_d    = byte_q;
    bit_d     = bit_q;
    ph_d      = ph_q;
    ref_d     = ref_q;
    seg_d     = seg_q;
    bright_d  = bright_q;
    on_d      = on_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    if (state_q == S_IDLE) begin
      ph_d = '0;
      if (start) begin
        state_d   = S_START0;
        frame_d   = FR_CMD;
        byte_d    = '0;
        bit_d     = '0;
        ref_d     = '0;
        seg_d     = seg_data;
        bright_d  = brightness;
        on_d      = display_on;
        ack_err_d = 1'b0;
      end else if (REFRESH_PERIOD > 0) begin
        ref_d = ref_q + 1'b1;
      end
    end else begin
      ph_d = phase_end ? '0 : ph_q + 1'b1;
      if (phase_end) begin
        case (state_q)
          S_START0: state_d = S_START1;
          S_START1: begin
            state_d = S_BIT_LO;
            byte_d  = '0;
            bit_d   = '0;
          end
          S_BIT_LO: state_d = S_BIT_HI;
          S_BIT_HI: begin
            state_d = (bit_q == 3'd7) ? S_ACK_LO : S_BIT_LO;
            bit_d   = bit_q + 1'b1;
          end
          S_ACK_LO: state_d = S_ACK_HI;
          S_ACK_HI: begin
            // A released (high) DIO at the end of the 9th clock means no ACK;
            // the frame carries on regardless.
            if (dio_sync_q[1]) ack_err_d = 1'b1;
            if (frame_q == FR_ADDR && byte_q != BY_LAST) begin
              state_d = S_BIT_LO;
              byte_d  = byte_q + 1'b1;
              bit_d   = '0;
            end else begin
              state_d = S_STOP0;
            end
          end
          S_STOP0: state_d = S_STOP1;
          S_STOP1: state_d = S_STOP2;
          S_STOP2: begin
            byte_d = '0;
            case (frame_q)
              FR_CMD:  begin state_d = S_START0; frame_d = FR_ADDR; end
              FR_ADDR: begin state_d = S_START0; frame_d = FR_CTRL; end
              default: begin state_d = S_IDLE;   done_d  = 1'b1;    end
            endcase
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Pin levels for the upcoming phase, registered so they switch cleanly on
  // the first clock of each phase.
  always_comb begin
    nxt_byte = tx_byte(frame_d, byte_d, seg_q, on_q, bright_q);
    nxt_bit  = nxt_byte[bit_d];
    clk_d    = 1'b1;
    oe_d     = 1'b0;
    case (state_d)
      S_START1: oe_d = 1'b1;
      S_BIT_LO: begin clk_d = 1'b0; oe_d = ~nxt_bit; end
      S_BIT_HI: oe_d = ~nxt_bit;
      S_ACK_LO: clk_d = 1'b0;
      S_STOP0:  begin clk_d = 1'b0; oe_d = 1'b1; end
      S_STOP1:  oe_d = 1'b1;
      default:  begin clk_d = 1'b1; oe_d = 1'b0; end
    endcase
  end

  // State and shadow registers; reset returns the bus to idle immediately.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      frame_q    <= FR_CMD;
      byte_q     <= '0;
      bit_q      <= '0;
      ph_q       <= '0;
      ref_q      <= '0;
      seg_q      <= '0;
      bright_q   <= '0;
      on_q       <= 1'b0;
      ack_err_q  <= 1'b0;
      done_q     <= 1'b0;
      clk_q      <= 1'b1;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      byte_q     <= byte_d;
      bit_q      <= bit_d;
      ph_q       <= ph_d;
      ref_q      <= ref_d;
      seg_q      <= seg_d;
      bright_q   <= bright_d;
      on_q       <= on_d;
      ack_err_q  <= ack_err_d;
      done_q     <= done_d;
      clk_q      <= clk_d;
      oe_q       <= oe_d;
    end
  end

  // Two-flop synchroniser for the DIO readback pin.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) dio_sync_q <= 2'b11;
    else        dio_sync_q <= {dio_sync_q[0], tm1637_dio_in};
  end

endmodule
